// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: shares one I2C master between two configuration queues.
// Each port owns a one-deep request slot. Grants are round-robin, the
// granted transaction is forwarded with a one-cycle m_start, and the
// slot stays busy until the master finishes or the start watchdog fires.
module i2c_bus_arbiter #(
  parameter int START_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_start,
  input  logic [6:0] req0_address,
  input  logic [7:0] req0_data_0,
  input  logic [7:0] req0_data_1,
  output logic       req0_busy,
  input  logic       req1_start,
  input  logic [6:0] req1_address,
  input  logic [7:0] req1_data_0,
  input  logic [7:0] req1_data_1,
  output logic       req1_busy,
  output logic       m_start,
  output logic [6:0] m_address,
  output logic [7:0] m_data_0,
  output logic [7:0] m_data_1,
  input  logic       m_busy,
  output logic [1:0] grant,
  output logic       timeout_err
);

  localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       pending_q, pending_d;
  logic [22:0]      slot_q [2];
  logic [22:0]      slot_d [2];
  logic [1:0]       start_w;
  logic [1:0]       take_w;
  logic [22:0]      req_word_w [2];
  logic [1:0]       clear_w;
  logic             sel_w;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m_start_q, m_start_d;
  logic [22:0]      m_word_q, m_word_d;
  logic [1:0]       grant_q, grant_d;
  logic             timeout_q, timeout_d;

  assign start_w       = {req1_start, req0_start};
  assign req_word_w[0] = {req0_address, req0_data_0, req0_data_1};
  assign req_word_w[1] = {req1_address, req1_data_0, req1_data_1};

  // A start is only accepted into an empty slot; a start on an occupied
  // slot (including the one completing this cycle) is dropped.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_take
      assign take_w[gi] = start_w[gi] & ~pending_q[gi];
    end
  endgenerate

  // Tie goes to the port that was not served last; a lone request wins.
  assign sel_w = (pending_q == 2'b11) ? ~last_grant_q : pending_q[1];

  // Per-port slot next state: completion clears, an accepted start latches.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pending_d[i] = pending_q[i];
      slot_d[i]    = slot_q[i];
      if (clear_w[i]) begin
        pending_d[i] = 1'b0;
      end else if (take_w[i]) begin
        pending_d[i] = 1'b1;
        slot_d[i]    = req_word_w[i];
      end
    end
  end

  // Arbitration FSM next state and registered bus-side outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    m_start_d    = 1'b0;
    m_word_d     = m_word_q;
    grant_d      = grant_q;
    timeout_d    = 1'b0;
    clear_w      = 2'b00;
    case (state_q)
      ST_IDLE: begin
        grant_d = 2'b00;
        if ((|pending_q) && !m_busy) begin
          owner_d   = sel_w;
          m_word_d  = slot_q[sel_w];
          grant_d   = sel_w ? 2'b10 : 2'b01;
          m_start_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (m_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Master never acknowledged the start: abort and free the slot.
          timeout_d        = 1'b1;
          clear_w[owner_q] = 1'b1;
          last_grant_d     = owner_q;
          grant_d          = 2'b00;
          state_d          = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!m_busy) begin
          clear_w[owner_q] = 1'b1;
          last_grant_d     = owner_q;
          grant_d          = 2'b00;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any queued or active work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= 2'b00;
      slot_q[0]    <= '0;
      slot_q[1]    <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      m_start_q    <= 1'b0;
      m_word_q     <= '0;
      grant_q      <= 2'b00;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      slot_q[0]    <= slot_d[0];
      slot_q[1]    <= slot_d[1];
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      m_start_q    <= m_start_d;
      m_word_q     <= m_word_d;
      grant_q      <= grant_d;
      timeout_q    <= timeout_d;
    end
  end

  assign req0_busy                        = pending_q[0];
  assign req1_busy                        = pending_q[1];
  assign m_start                          = m_start_q;
  assign {m_address, m_data_0, m_data_1}  = m_word_q;
  assign grant                            = grant_q;
  assign timeout_err                      = timeout_q;

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Two-port arbiter sharing the single I2C master between the HDMI transmitter configuration queue (port 0) and the audio codec configuration queue (port 1). It accepts one-cycle start pulses with a 7-bit slave address and two data bytes per port. It holds each request in a one-deep slot, grants the master round-robin, forwards the transaction and reports per-port busy until the master finishes. A watchdog recovers from a master that never asserts busy.

## Interface
- START_TIMEOUT, 16: cycles after m_start to wait for m_busy rising before aborting (range 2..65535)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req0_start  in  1  port 0 transaction request, one-cycle pulse
- req0_address  in  7  port 0 slave address, sampled with req0_start
- req0_data_0 / req0_data_1  in  8 each  port 0 register/value bytes, sampled with req0_start
- req0_busy  out  1  port 0 slot occupied
- req1_start, req1_address, req1_data_0, req1_data_1, req1_busy: same as port 0, for port 1
- m_start  out  1  one-cycle start to I2C master
- m_address  out  7  forwarded address
- m_data_0 / m_data_1  out  8 each  forwarded bytes
- m_busy  in  1  I2C master busy
- grant  out  2  one-hot owner of master, 0 when idle
- timeout_err  out  1  one-cycle pulse on watchdog abort

## Operation
- Per-port slot: pending bit plus 23-bit holding register {address, data_0, data_1}.
- A start with pending=0 latches the inputs and sets pending. A start with pending=1 is dropped; the held contents are unchanged.
- reqN_busy = pendingN (registered). Start sampled at edge E sets busy high after E and clears it at the completion edge.
- FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: if any pending and m_busy=0, choose the port, load m_address/m_data from its slot, set grant and m_start=1, and go to ISSUE. Otherwise stay in IDLE with grant=0.
- Round-robin: if both ports are pending, pick the port other than last_grant. last_grant resets to 1, so port 0 wins the first tie. A single pending port always wins.
- ISSUE: m_start=0, clear counter, go to WAIT_BUSY.
- WAIT_BUSY: if m_busy=1, go to WAIT_DONE.
  - Else increment the counter; at counter = START_TIMEOUT-1 with m_busy=0, pulse timeout_err, clear the granted pending bit, update last_grant and go to IDLE.
- WAIT_DONE: on m_busy=0, clear the granted pending bit, update last_grant, set grant=0 and go to IDLE.
- m_address/m_data hold their value from load until the next load. Bus-side outputs are not required to return to 0.
- Counter width $clog2(START_TIMEOUT); wrap is not possible because it stops at START_TIMEOUT-1.
- A new start on the port that is just completing, in the same cycle as completion, is dropped (pending still 1 at that edge). A start on the other port is accepted in any state.

## Timing
- Reset values: req0_busy=req1_busy=0, m_start=0, m_address=0, m_data_0=m_data_1=0, grant=0, timeout_err=0, state IDLE, last_grant=1, pending=0, counter=0.
- Reset mid-transaction aborts everything. Pending requests are lost and no error is pulsed. The external master is not reset by this block.
- Latency: reqN_start high in cycle n gives reqN_busy high in n+1 and m_start high in n+2 (if idle and m_busy=0).
- m_start is exactly one cycle wide per grant.
- Completion: m_busy low in cycle k during WAIT_DONE gives grant=0 and reqN_busy=0 in k+1. The next m_start is no earlier than k+2.
- Timeout: with m_start in cycle s and m_busy never high, timeout_err is high in cycle s+START_TIMEOUT+1 together with the busy drop.
- No combinational path from any input to any output.

## Test plan
- Single port 0 request (addr 0x72, 0x41, 0x10), master busy for 20 cycles -> m_start at n+2 with 0x72/0x41/0x10, grant=01, req0_busy high until cycle after m_busy falls.
- Simultaneous starts on both ports after reset -> port 0 served first, then port 1. Both busy high from n+1. Port 1 busy stays high until its own completion.
- Back-to-back contention, 4 rounds with both always re-requesting on busy fall -> grants alternate 01,10,01,10.
- Duplicate start on port 1 while pending (second data 0xAA) -> forwarded data is the first latched value, only one m_start.
- Master never asserts busy, START_TIMEOUT=16 -> timeout_err pulse at s+17, req busy drops, other pending port then granted.
- rst asserted during WAIT_DONE with both pending -> next cycle all outputs at reset values, no m_start after release until a new start.
